// File: rtl/cpu_checker.sv
// rtl/cpu_checker.sv - byte-serial recognizer for CPU register/memory write trace records
//
// Consumes one ASCII character per clock and flags a just-completed record:
//   ^TIME@PC: SP* $GRF SP* <= SP* DATA#   -> format_type = 01 (register write)
//   ^TIME@PC: SP* *ADDR SP* <= SP* DATA#  -> format_type = 10 (memory write)
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high
//   char        - ASCII character sampled every rising edge
//   format_type - 00 none/invalid, 01 register write, 10 memory write (one cycle after '#')
module cpu_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    typedef enum logic [4:0] {
        S_IDLE, S_GOT_CARET, S_TIME, S_GOT_AT, S_PC, S_GOT_COLON,
        S_GOT_DOLLAR, S_GRF, S_GOT_STAR, S_ADDR, S_PRE_LT, S_GOT_LT,
        S_GOT_EQ, S_DATA, S_DONE_REG, S_DONE_MEM, S_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       kind_q, kind_d;     // 1 = memory record, 0 = register record

    logic is_dig, is_hex, is_sp;

    always_comb begin
        is_dig = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dig || ((char >= 8'h61) && (char <= 8'h66));
        is_sp  = (char == 8'h20);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        if (char == 8'h5e) begin
            // '^' restarts parsing from any state
            state_d = S_GOT_CARET;
            cnt_d   = 4'd0;
            kind_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ; // everything except '^' is ignored while idle
                S_GOT_CARET: begin
                    if (is_dig) begin state_d = S_TIME; cnt_d = 4'd1; end
                    else state_d = S_ERROR;
                end
                S_TIME: begin
                    if (is_dig && cnt_q < 4'd4) cnt_d = cnt_q + 4'd1;
                    else if (char == 8'h40) begin state_d = S_GOT_AT; cnt_d = 4'd0; end
                    else state_d = S_ERROR;
                end
                S_GOT_AT: begin
                    if (is_hex) begin state_d = S_PC; cnt_d = 4'd1; end
                    else state_d = S_ERROR;
                end
                S_PC: begin
                    if (is_hex && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    else if (char == 8'h3a && cnt_q == 4'd8) begin
                        state_d = S_GOT_COLON;
                        cnt_d   = 4'd0;
                    end else state_d = S_ERROR;
                end
                S_GOT_COLON: begin
                    if (is_sp) state_d = S_GOT_COLON;
                    else if (char == 8'h24) begin state_d = S_GOT_DOLLAR; kind_d = 1'b0; end
                    else if (char == 8'h2a) begin state_d = S_GOT_STAR; kind_d = 1'b1; end
                    else state_d = S_ERROR;
                end
                S_GOT_DOLLAR: begin
                    if (is_dig) begin state_d = S_GRF; cnt_d = 4'd1; end
                    else state_d = S_ERROR;
                end
                S_GRF: begin
                    // entering GRF guarantees at least one digit, so terminators are always in range
                    if (is_dig && cnt_q < 4'd4) cnt_d = cnt_q + 4'd1;
                    else if (is_sp) begin state_d = S_PRE_LT; cnt_d = 4'd0; end
                    else if (char == 8'h3c) begin state_d = S_GOT_LT; cnt_d = 4'd0; end
                    else state_d = S_ERROR;
                end
                S_GOT_STAR: begin
                    if (is_hex) begin state_d = S_ADDR; cnt_d = 4'd1; end
                    else state_d = S_ERROR;
                end
                S_ADDR: begin
                    if (is_hex && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    else if (is_sp && cnt_q == 4'd8) begin state_d = S_PRE_LT; cnt_d = 4'd0; end
                    else if (char == 8'h3c && cnt_q == 4'd8) begin state_d = S_GOT_LT; cnt_d = 4'd0; end
                    else state_d = S_ERROR;
                end
                S_PRE_LT: begin
                    if (is_sp) state_d = S_PRE_LT;
                    else if (char == 8'h3c) state_d = S_GOT_LT;
                    else state_d = S_ERROR;
                end
                S_GOT_LT: begin
                    if (char == 8'h3d) state_d = S_GOT_EQ;
                    else state_d = S_ERROR;
                end
                S_GOT_EQ: begin
                    if (is_sp) state_d = S_GOT_EQ;
                    else if (is_hex) begin state_d = S_DATA; cnt_d = 4'd1; end
                    else state_d = S_ERROR;
                end
                S_DATA: begin
                    if (is_hex && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    else if (char == 8'h23 && cnt_q == 4'd8) begin
                        state_d = kind_q ? S_DONE_MEM : S_DONE_REG;
                        cnt_d   = 4'd0;
                    end else state_d = S_ERROR;
                end
                default: state_d = S_ERROR; // DONE_* and ERROR: only '^' escapes
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            kind_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    always_comb begin
        format_type = 2'b00;
        if (state_q == S_DONE_REG) format_type = 2'b01;
        else if (state_q == S_DONE_MEM) format_type = 2'b10;
    end

endmodule

// File: tb/tb_cpu_checker.sv
// tb/tb_cpu_checker.sv - directed self-checking bench for cpu_checker
module tb_cpu_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char;
    logic [1:0] format_type;

    int checks   = 0;
    int failures = 0;

    cpu_checker dut (
        .clk        (clk),
        .reset      (reset),
        .char       (char),
        .format_type(format_type)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] exp);
        checks++;
        assert (format_type === exp) else begin
            failures++;
            $error("FAIL %s: format_type=%b expected=%b", tag, format_type, exp);
        end
    endtask

    // Drive c from a negedge; return at the following negedge so format_type reflects c.
    task automatic put(input string tag, input logic [7:0] c, input logic [1:0] exp);
        char = c;
        @(negedge clk);
        check(tag, exp);
    endtask

    // Every character but the last must leave format_type at 00.
    task automatic feed(input string tag, input string s, input logic [1:0] exp_last);
        for (int i = 0; i < s.len(); i++)
            put(tag, s[i], (i == s.len() - 1) ? exp_last : 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        char  = 8'h5e;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 2'b00);
        reset = 1'b0;

        feed("mem_spaces", "^123@000030fc: *00000001 <= 89abcdef#", 2'b10);
        put("mem_clear_caret", "^", 2'b00);
        put("mem_clear_6", "6", 2'b00);
        put("mem_clear_4", "4", 2'b00);

        feed("reg_spaces", "^5@0000300c: $31 <= 0000abcd#", 2'b01);
        feed("reg_nospace_b2b", "^5@0000300c:$31<=0000abcd#", 2'b01);
        put("done_then_bad", "x", 2'b00);

        feed("time_5dig", "^12345@0000300c:$31<=0000abcd#", 2'b00);
        feed("grf_5dig", "^5@0000300c:$12345<=0000abcd#", 2'b00);
        feed("pc_7dig", "^123@00030fc: *00000001 <= 89abcdef#", 2'b00);
        feed("data_9dig", "^5@0000300c:$31<=0000abcd1#", 2'b00);
        feed("addr_7dig", "^5@0000300c:*0000001<=0000abcd#", 2'b00);
        feed("time0_grf9999", "^0@ffffffff:$9999<=12345678#", 2'b01);
        feed("upper_data", "^5@0000300c:$31<=ABCDEF00#", 2'b00);
        feed("sp_lt_eq", "^5@0000300c:$31< =0000abcd#", 2'b00);
        feed("sp_before_colon", "^5@0000300c :$31<=0000abcd#", 2'b00);
        feed("error_sticky", "5@0000300c:$31<=0000abcd#", 2'b00);

        feed("restart_prefix", "^5@0000300c: $3", 2'b00);
        feed("restart_mem", "^1@00000000:*deadbeef<=12345678#", 2'b10);
        feed("b2b_reg", "^77@0000abcd:$2 <=ffffffff#", 2'b01);
        feed("b2b_mem", "^9@00000004:*00000010 <=00000000#", 2'b10);

        feed("rst_prefix", "^5@0000300c:$31<=0000abc", 2'b00);
        reset = 1'b1;
        put("rst_cycle", "d", 2'b00);
        reset = 1'b0;
        put("rst_hash", "#", 2'b00);
        feed("idle_no_caret", "5@0000300c:$31<=0000abcd#", 2'b00);
        put("idle_nul", 8'h00, 2'b00);
        feed("after_rst_reg", "^42@0000300c:$31<=0000abcd#", 2'b01);
        feed("after_rst_mem", "^42@0000300c:*000000ff<=0000abcd#", 2'b10);
        put("final_clear", " ", 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
